// File: rtl/sample_mixer_if.sv
// Handshake bundle between the drum-voice mixer and its control/codec-writer side.
// The master side is the control plus codec writer; the slave side is the mixer.
interface sample_mixer_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32
);
  logic             en;
  logic [IN_W-1:0]  audio0, audio1, audio2, audio3;
  logic [3:0]       mute;
  logic [1:0]       vol;
  logic             sample_ready;
  logic [OUT_W-1:0] mix_down;
  logic             sample_valid;
  logic [7:0]       drop_count;

  modport master (
    output en, audio0, audio1, audio2, audio3, mute, vol, sample_ready,
    input  mix_down, sample_valid, drop_count
  );
  modport slave (
    input  en, audio0, audio1, audio2, audio3, mute, vol, sample_ready,
    output mix_down, sample_valid, drop_count
  );
endinterface

// File: rtl/sample_mixer_pipe.sv
// Sample-rate paced four-voice mixer: unsigned->signed, mute, sum, left-justify,
// master attenuation, then a one-deep output buffer with drop counting.
module sample_mixer_lane #(
  parameter int IN_W = 8
) (
  input  logic [IN_W-1:0]   audio,
  input  logic              mute,
  output logic signed [IN_W:0] v
);
  // Recentre around the unsigned midpoint; one extra bit holds the sign.
  assign v = mute ? '0
                  : $signed({1'b0, audio}) - $signed({2'b01, {(IN_W-1){1'b0}}});
endmodule

module sample_mixer_pipe #(
  parameter int SAMPLE_DIV = 1042,
  parameter int IN_W       = 8,
  parameter int OUT_W      = 32,
  parameter int NUM_LANES  = 4
) (
  input  logic           clk,
  input  logic           reset,
  sample_mixer_if.slave  bus
);
  localparam int CNT_W  = $clog2(SAMPLE_DIV);
  localparam int STAGES = 2;
  localparam int SUM_W  = IN_W + 3;
  localparam int PAD    = OUT_W - SUM_W;

  typedef enum logic {EMPTY, FULL} state_t;

  logic [CNT_W-1:0]                    cnt;
  logic                                tick;
  logic [STAGES:1]                     vld_pipe;
  logic [NUM_LANES-1:0][IN_W-1:0]      audio;
  logic [NUM_LANES-1:0][IN_W:0]        lane_v;
  logic [NUM_LANES-1:0][IN_W:0]        s1_v;
  logic signed [SUM_W-1:0]             sum_c, sum_q;
  logic signed [OUT_W-1:0]             scaled;
  logic                                offer;
  state_t                              state;

  assign tick  = bus.en && (cnt == CNT_W'(SAMPLE_DIV - 1));
  assign audio = {bus.audio3, bus.audio2, bus.audio1, bus.audio0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    sample_mixer_lane #(.IN_W(IN_W)) u_lane (
      .audio (audio[g]),
      .mute  (bus.mute[g]),
      .v     (lane_v[g])
    );
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NUM_LANES; i++)
      sum_c = sum_c + $signed({{(SUM_W-IN_W-1){s1_v[i][IN_W]}}, s1_v[i]});
  end

  // Attenuation is applied on the way into the buffer, using the current vol.
  assign scaled = $signed({sum_q, {PAD{1'b0}}}) >>> bus.vol;
  assign offer  = vld_pipe[STAGES] && bus.en;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      vld_pipe <= '0;
      s1_v     <= '0;
      sum_q    <= '0;
    end else begin
      if (!bus.en || tick) cnt <= '0;
      else                 cnt <= cnt + CNT_W'(1);
      // Dropping en flushes in-flight samples without counting them.
      if (!bus.en) vld_pipe <= '0;
      else         vld_pipe <= {vld_pipe[STAGES-1:1], tick};
      if (tick)        s1_v  <= lane_v;
      if (vld_pipe[1]) sum_q <= sum_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= EMPTY;
      bus.mix_down     <= '0;
      bus.sample_valid <= 1'b0;
      bus.drop_count   <= '0;
    end else begin
      case (state)
        EMPTY: if (offer) begin
          bus.mix_down     <= scaled;
          bus.sample_valid <= 1'b1;
          state            <= FULL;
        end
        FULL: begin
          if (offer && bus.sample_ready) begin
            bus.mix_down <= scaled;
          end else if (offer) begin
            if (bus.drop_count != 8'hFF) bus.drop_count <= bus.drop_count + 8'd1;
          end else if (bus.sample_ready) begin
            bus.sample_valid <= 1'b0;
            state            <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_mixer_pipe.sv
// Directed bench for sample_mixer_pipe with SAMPLE_DIV=4; inputs change and
// outputs are sampled on the falling edge.
module tb_sample_mixer_pipe;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  sample_mixer_if #(.IN_W(8), .OUT_W(32)) bus ();

  sample_mixer_pipe #(.SAMPLE_DIV(4), .IN_W(8), .OUT_W(32), .NUM_LANES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] MIX_A = 32'h0FE00000;  // audio0=255, rest 128
  localparam logic [31:0] MIX_Z = 32'hC0000000;  // all voices 0

  logic [7:0]  lv_a0   [5] = '{8'd255, 8'd255, 8'd255, 8'd0, 8'd0};
  logic [7:0]  lv_oth  [5] = '{8'd128, 8'd128, 8'd128, 8'd0, 8'd0};
  logic [3:0]  lv_mute [5] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
  logic [1:0]  lv_vol  [5] = '{2'd0, 2'd2, 2'd0, 2'd0, 2'd3};
  logic [31:0] lv_exp  [5] = '{32'h0FE00000, 32'h03F80000, 32'h00000000,
                               32'hC0000000, 32'hF8000000};

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_voices(input logic [7:0] a0, a1, a2, a3);
    bus.audio0 = a0; bus.audio1 = a1; bus.audio2 = a2; bus.audio3 = a3;
  endtask

  // Reset for one edge, then release with en=1; returns on the release negedge.
  task automatic do_reset();
    reset = 1'b0; bus.en = 1'b0;
    cyc(1);
    reset = 1'b1; bus.en = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.en = 1'b0;
    cyc(1);
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.sample_valid); end
    checks++; if (bus.mix_down !== 32'h0) begin errors++; $display("FAIL reset_mix: got %h want 00000000", bus.mix_down); end
    checks++; if (bus.drop_count !== 8'h0) begin errors++; $display("FAIL reset_drop: got %0d want 0", bus.drop_count); end
  endtask

  task automatic test_silence();
    set_voices(8'd128, 8'd128, 8'd128, 8'd128);
    bus.mute = 4'b0; bus.vol = 2'd0; bus.sample_ready = 1'b1;
    do_reset();
    cyc(5);
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL silence_early: got valid=%b want 0", bus.sample_valid); end
    cyc(1);
    checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL silence_first: got valid=%b want 1", bus.sample_valid); end
    checks++; if (bus.mix_down !== 32'h0) begin errors++; $display("FAIL silence_mix: got %h want 00000000", bus.mix_down); end
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL silence_gap%0d: got valid=%b want 0", k, bus.sample_valid); end
    end
    cyc(1);
    checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL silence_period: got valid=%b want 1", bus.sample_valid); end
  endtask

  task automatic test_levels();
    logic [31:0] val;
    bit          got;
    for (int t = 0; t < 5; t++) begin
      set_voices(lv_a0[t], lv_oth[t], lv_oth[t], lv_oth[t]);
      bus.mute = lv_mute[t]; bus.vol = lv_vol[t]; bus.sample_ready = 1'b1;
      do_reset();
      got = 1'b0; val = '0;
      for (int i = 0; i < 10 && !got; i++) begin
        cyc(1);
        if (bus.sample_valid === 1'b1) begin got = 1'b1; val = bus.mix_down; end
      end
      checks++;
      if (!got || val !== lv_exp[t]) begin
        errors++; $display("FAIL level%0d: got %h (valid seen=%0d) want %h", t, val, got, lv_exp[t]);
      end
    end
    bus.vol = 2'd0; bus.mute = 4'b0;
  endtask

  task automatic test_backpressure();
    set_voices(8'd255, 8'd128, 8'd128, 8'd128);
    bus.sample_ready = 1'b0;
    do_reset();
    cyc(6);
    checks++; if (bus.sample_valid !== 1'b1 || bus.mix_down !== MIX_A) begin errors++; $display("FAIL bp_first: got valid=%b %h want 1 %h", bus.sample_valid, bus.mix_down, MIX_A); end
    set_voices(8'd0, 8'd0, 8'd0, 8'd0);
    cyc(4);
    checks++; if (bus.mix_down !== MIX_A) begin errors++; $display("FAIL bp_hold1: got %h want %h", bus.mix_down, MIX_A); end
    checks++; if (bus.drop_count !== 8'd1) begin errors++; $display("FAIL bp_drop1: got %0d want 1", bus.drop_count); end
    set_voices(8'd255, 8'd255, 8'd255, 8'd255);
    cyc(4);
    checks++; if (bus.mix_down !== MIX_A || bus.sample_valid !== 1'b1) begin errors++; $display("FAIL bp_hold2: got valid=%b %h want 1 %h", bus.sample_valid, bus.mix_down, MIX_A); end
    checks++; if (bus.drop_count !== 8'd2) begin errors++; $display("FAIL bp_drop2: got %0d want 2", bus.drop_count); end
    bus.sample_ready = 1'b1;
    cyc(1);
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL bp_transfer: got valid=%b want 0", bus.sample_valid); end
    checks++; if (bus.drop_count !== 8'd2) begin errors++; $display("FAIL bp_drop_kept: got %0d want 2", bus.drop_count); end
    bus.sample_ready = 1'b0;
    cyc(4 * 302);
    checks++; if (bus.drop_count !== 8'd255) begin errors++; $display("FAIL bp_saturate: got %0d want 255", bus.drop_count); end
    checks++; if (bus.mix_down !== 32'h3F800000) begin errors++; $display("FAIL bp_sat_hold: got %h want 3f800000", bus.mix_down); end
  endtask

  task automatic test_en_timing();
    set_voices(8'd255, 8'd128, 8'd128, 8'd128);
    bus.sample_ready = 1'b1;
    do_reset();
    cyc(4);
    bus.en = 1'b0;
    cyc(2);
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL en_flush: got valid=%b want 0", bus.sample_valid); end
    cyc(6);
    checks++; if (bus.sample_valid !== 1'b0 || bus.drop_count !== 8'd0) begin errors++; $display("FAIL en_idle: got valid=%b drop=%0d want 0 0", bus.sample_valid, bus.drop_count); end
    bus.en = 1'b1;
    cyc(5);
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL en_rise_early: got valid=%b want 0", bus.sample_valid); end
    cyc(1);
    checks++; if (bus.sample_valid !== 1'b1 || bus.mix_down !== MIX_A) begin errors++; $display("FAIL en_rise_first: got valid=%b %h want 1 %h", bus.sample_valid, bus.mix_down, MIX_A); end
  endtask

  task automatic test_back_to_back();
    set_voices(8'd255, 8'd128, 8'd128, 8'd128);
    bus.sample_ready = 1'b0;
    do_reset();
    cyc(6);
    checks++; if (bus.mix_down !== MIX_A) begin errors++; $display("FAIL b2b_first: got %h want %h", bus.mix_down, MIX_A); end
    set_voices(8'd0, 8'd0, 8'd0, 8'd0);
    cyc(3);
    bus.sample_ready = 1'b1;
    cyc(1);
    checks++; if (bus.sample_valid !== 1'b1 || bus.mix_down !== MIX_Z) begin errors++; $display("FAIL b2b_load: got valid=%b %h want 1 %h", bus.sample_valid, bus.mix_down, MIX_Z); end
    checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL b2b_nodrop: got %0d want 0", bus.drop_count); end
  endtask

  task automatic test_reset_full();
    set_voices(8'd255, 8'd128, 8'd128, 8'd128);
    bus.sample_ready = 1'b0;
    do_reset();
    cyc(26);
    checks++; if (bus.drop_count !== 8'd5 || bus.sample_valid !== 1'b1) begin errors++; $display("FAIL rf_setup: got drop=%0d valid=%b want 5 1", bus.drop_count, bus.sample_valid); end
    reset = 1'b0;
    cyc(1);
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL rf_valid: got %b want 0", bus.sample_valid); end
    checks++; if (bus.mix_down !== 32'h0) begin errors++; $display("FAIL rf_mix: got %h want 00000000", bus.mix_down); end
    checks++; if (bus.drop_count !== 8'd0) begin errors++; $display("FAIL rf_drop: got %0d want 0", bus.drop_count); end
    reset = 1'b1;
    cyc(5);
    checks++; if (bus.sample_valid !== 1'b0) begin errors++; $display("FAIL rf_restart_early: got valid=%b want 0", bus.sample_valid); end
    cyc(1);
    checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL rf_restart: got valid=%b want 1", bus.sample_valid); end
  endtask

  initial begin
    reset = 1'b0; bus.en = 1'b0; bus.mute = 4'b0; bus.vol = 2'd0; bus.sample_ready = 1'b0;
    set_voices(8'd128, 8'd128, 8'd128, 8'd128);
    test_reset();
    test_silence();
    test_levels();
    test_backpressure();
    test_en_timing();
    test_back_to_back();
    test_reset_full();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
